// File: rtl/pattern_generator_pkg.sv
// Shared debug-path definitions: playback/receiver state encodings and entry byte geometry.
package pattern_generator_pkg;

    typedef enum logic [1:0] {
        STATE_LOAD,
        STATE_PLAY,
        STATE_STOPPED
    } pattern_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Number of whole bytes needed to carry one entry of the given width.
    function automatic int width_bytes(input int width_bits);
        return (width_bits + 7) / 8;
    endfunction

endpackage

// File: rtl/sram_1r1w.sv
// Simple dual-port memory: one synchronous write port, one registered read port.
module sram_1r1w #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] read_address,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; consumers qualify read_data with their own valid.
    // NOTE: non-blocking assignments in clocked blocks so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
        if (read_enable) begin
            read_data <= mem[read_address];
        end
    end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, and flags bytes with a bad stop bit.
module uart_receive
    import pattern_generator_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 54
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_char,
    output logic       rx_char_valid,
    output logic       rx_frame_error
);

    localparam int TICK_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLOCKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLOCKS_PER_BIT / 2 - 1);

    rx_state_t         state, state_next;
    logic [1:0]        rx_sync;
    logic              rx_bit;
    logic [TICK_W-1:0] tick, tick_next;
    logic [2:0]        bit_index, bit_index_next;
    logic [7:0]        shift, shift_next;
    logic              char_valid_next, frame_error_next;

    assign rx_bit  = rx_sync[1];
    assign rx_char = shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RX_IDLE;
            rx_sync        <= 2'b11;
            tick           <= '0;
            bit_index      <= '0;
            shift          <= '0;
            rx_char_valid  <= 1'b0;
            rx_frame_error <= 1'b0;
        end else begin
            state          <= state_next;
            rx_sync        <= {rx_sync[0], uart_rx};
            tick           <= tick_next;
            bit_index      <= bit_index_next;
            shift          <= shift_next;
            rx_char_valid  <= char_valid_next;
            rx_frame_error <= frame_error_next;
        end
    end

    // NOTE: every combinational output is given a default first so no latch is inferred.
    always_comb begin
        state_next       = state;
        tick_next        = tick + 1'b1;
        bit_index_next   = bit_index;
        shift_next       = shift;
        char_valid_next  = 1'b0;
        frame_error_next = 1'b0;
        case (state)
            RX_IDLE: begin
                tick_next = '0;
                if (!rx_bit) state_next = RX_START;
            end
            RX_START: begin
                // A start bit that is no longer low at mid-bit was a glitch.
                if (tick == TICK_HALF) begin
                    tick_next      = '0;
                    bit_index_next = '0;
                    state_next     = rx_bit ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick == TICK_LAST) begin
                    tick_next      = '0;
                    shift_next     = {rx_bit, shift[7:1]};
                    bit_index_next = bit_index + 1'b1;
                    if (bit_index == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick == TICK_LAST) begin
                    tick_next = '0;
                    if (rx_bit) begin
                        char_valid_next = 1'b1;
                        state_next      = RX_IDLE;
                    end else begin
                        frame_error_next = 1'b1;
                        state_next       = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // A low stop bit must not be mistaken for the next start bit.
                tick_next = '0;
                if (rx_bit) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/pattern_generator.sv
// Loads pattern entries over UART into a buffer, then replays them one entry per enabled cycle.
module pattern_generator
    import pattern_generator_pkg::*;
#(
    parameter int PATTERN_WIDTH_BITS = 32,
    parameter int PATTERN_SIZE       = 64,
    parameter int CLOCKS_PER_BIT     = 54
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          playback_enable,
    output logic [PATTERN_WIDTH_BITS-1:0] pattern_data,
    output logic                          pattern_valid,
    output logic [$clog2(PATTERN_SIZE):0] entry_count,
    output logic                          playing,
    output logic                          overflow,
    output logic                          frame_error
);

    localparam int WIDTH_BYTES = width_bytes(PATTERN_WIDTH_BITS);
    localparam int ASSEMBLY_W  = WIDTH_BYTES * 8;
    localparam int ADDR_W      = $clog2(PATTERN_SIZE);
    localparam int COUNT_W     = ADDR_W + 1;
    localparam int BYTE_W      = (WIDTH_BYTES > 1) ? $clog2(WIDTH_BYTES) : 1;
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(PATTERN_SIZE);
    localparam logic [BYTE_W-1:0]  LAST_BYTE  = BYTE_W'(WIDTH_BYTES - 1);

    pattern_state_t          state, state_next;
    logic [BYTE_W-1:0]       load_byte;
    logic [COUNT_W-1:0]      play_entry;
    logic [ASSEMBLY_W-1:0]   assembly, assembly_merged;
    logic [7:0]              rx_char;
    logic                    rx_char_valid, rx_frame_error;
    logic                    buffer_full, start_accept, load_accept, overflow_set;
    logic                    read_issue, last_read, write_enable;
    logic [PATTERN_WIDTH_BITS-1:0] read_data;

    uart_receive #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_uart_receive (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .rx_char       (rx_char),
        .rx_char_valid (rx_char_valid),
        .rx_frame_error(rx_frame_error)
    );

    sram_1r1w #(
        .WIDTH(PATTERN_WIDTH_BITS),
        .DEPTH(PATTERN_SIZE)
    ) u_sram (
        .clk          (clk),
        .write_enable (write_enable),
        .write_address(entry_count[ADDR_W-1:0]),
        .write_data   (assembly_merged[PATTERN_WIDTH_BITS-1:0]),
        .read_enable  (read_issue),
        .read_address (play_entry[ADDR_W-1:0]),
        .read_data    (read_data)
    );

    always_comb begin
        assembly_merged = assembly;
        for (int k = 0; k < WIDTH_BYTES; k++) begin
            if (load_byte == BYTE_W'(k)) assembly_merged[8*k +: 8] = rx_char;
        end

        buffer_full  = (entry_count == COUNT_FULL);
        // clear outranks start, and an accepted start outranks a completing byte.
        start_accept = start && !clear &&
                       (((state == STATE_LOAD) && (entry_count != '0)) || (state == STATE_STOPPED));
        load_accept  = (state == STATE_LOAD) && rx_char_valid && !clear && !start_accept && !buffer_full;
        overflow_set = (state == STATE_LOAD) && rx_char_valid && !clear && !start_accept && buffer_full;
        write_enable = load_accept && (load_byte == LAST_BYTE);
        read_issue   = (state == STATE_PLAY) && playback_enable && !clear;
        last_read    = read_issue && (play_entry == entry_count - 1'b1);

        state_next = state;
        if (clear) begin
            state_next = STATE_LOAD;
        end else begin
            case (state)
                STATE_LOAD:    if (start_accept) state_next = STATE_PLAY;
                STATE_PLAY:    if (last_read)    state_next = STATE_STOPPED;
                STATE_STOPPED: if (start_accept) state_next = STATE_PLAY;
                default:       state_next = STATE_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= STATE_LOAD;
            load_byte     <= '0;
            play_entry    <= '0;
            entry_count   <= '0;
            assembly      <= '0;
            pattern_valid <= 1'b0;
            overflow      <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state <= state_next;
            if (clear) begin
                load_byte     <= '0;
                play_entry    <= '0;
                entry_count   <= '0;
                assembly      <= '0;
                pattern_valid <= 1'b0;
                overflow      <= 1'b0;
                frame_error   <= 1'b0;
            end else begin
                pattern_valid <= read_issue;
                if (rx_frame_error) frame_error <= 1'b1;
                if (overflow_set)   overflow    <= 1'b1;
                if (load_accept) begin
                    assembly <= assembly_merged;
                    if (load_byte == LAST_BYTE) begin
                        load_byte   <= '0;
                        entry_count <= entry_count + 1'b1;
                    end else begin
                        load_byte <= load_byte + 1'b1;
                    end
                end
                if (start_accept) begin
                    load_byte  <= '0;
                    play_entry <= '0;
                end else if (read_issue) begin
                    play_entry <= play_entry + 1'b1;
                end
            end
        end
    end

    assign pattern_data = pattern_valid ? read_data : '0;
    assign playing      = (state == STATE_PLAY);

endmodule

// File: doc/pattern_generator.md
Name: pattern_generator

Overview:
- Stimulus-side counterpart to the embedded capture/dump debug path: receives pattern entries from a host over UART and stores them in an on-chip buffer.
- On command, replays the stored entries onto an internal bus, one entry per enabled cycle.
- Byte format matches the dump format: each entry is padded to whole bytes and sent least-significant byte first.
- Sits beside the logic analyzer in FPGA debug builds and drives test stimulus into the design under debug.

Parameters:
- PATTERN_WIDTH_BITS, 32, width of one pattern entry.
- PATTERN_SIZE, 64, number of entries in the buffer; must be a power of two and at least 2.
- CLOCKS_PER_BIT, 54, UART bit period in clk cycles (50 MHz / 921600 baud).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- uart_rx  in  1  serial input, idle high
- start  in  1  one-cycle pulse; begin playback
- clear  in  1  one-cycle pulse; discard buffer contents and return to loading
- playback_enable  in  1  advance playback by one entry this cycle
- pattern_data  out  PATTERN_WIDTH_BITS  replayed entry
- pattern_valid  out  1  pattern_data is valid this cycle
- entry_count  out  $clog2(PATTERN_SIZE)+1  number of complete entries loaded
- playing  out  1  high while in STATE_PLAY
- overflow  out  1  sticky; bytes were dropped because the buffer was full
- frame_error  out  1  sticky; a byte was received with a bad stop bit

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: all outputs 0; state STATE_LOAD; all counters 0; byte-assembly register 0.
- Entry geometry: WIDTH_BYTES = ceil(PATTERN_WIDTH_BITS/8). Byte k of an entry fills bits [8k+7:8k]. Bits above PATTERN_WIDTH_BITS in the last byte are discarded.
- STATE_LOAD, good byte received:
  - Byte goes into the assembly register at position load_byte; load_byte increments.
  - On the byte where load_byte == WIDTH_BYTES-1, the full word is written to the SRAM at address entry_count. entry_count increments the following cycle and load_byte returns to 0.
- STATE_LOAD, buffer full (entry_count == PATTERN_SIZE): further bytes are dropped and overflow is set.
- Frame error: the byte is dropped, load_byte does not advance, and frame_error is set. This applies in any state.
- Bytes arriving in STATE_PLAY or STATE_STOPPED are dropped silently; no flag is set.
- start in STATE_LOAD:
  - entry_count == 0: ignored.
  - Otherwise: any partial entry is discarded (load_byte cleared), play_entry = 0, go to STATE_PLAY.
- STATE_PLAY:
  - Each cycle with playback_enable=1, the SRAM is read at play_entry and play_entry increments.
  - pattern_valid=1 exactly one cycle later (SRAM read latency), with pattern_data = that entry.
  - If playback_enable is held, one entry is output per cycle with no bubbles.
  - When the read of entry entry_count-1 is issued, go to STATE_STOPPED. The final pattern_valid pulse still appears on the next cycle.
- pattern_data is 0 whenever pattern_valid=0.
- STATE_STOPPED:
  - start replays from entry 0 (go to STATE_PLAY).
  - The buffer contents and entry_count are retained.
- clear, in any state:
  - entry_count, load_byte and play_entry are set to 0; overflow and frame_error are cleared.
  - Go to STATE_LOAD. pattern_valid is 0 from the next cycle, so an in-flight read is suppressed.
- Simultaneous events:
  - clear and start in the same cycle: clear wins.
  - start in STATE_PLAY: ignored.
  - A byte completing in the same cycle as start in STATE_LOAD: the byte is dropped (start wins).
- Reset mid-operation: returns to the reset state immediately; SRAM contents become don't-care.

Decomposition:
- Shared debug package holds:
  - state enum pattern_state_t (STATE_LOAD, STATE_PLAY, STATE_STOPPED);
  - the function computing WIDTH_BYTES from a bit width, shared with the logic analyzer.
- Storage: existing sram_1r1w.
- Natural sub-module: uart_receive (bit sampling, start/stop detection, frame error), with outputs rx_char, rx_char_valid, rx_frame_error. The top level holds the FSM, byte assembly and playback.

Test Plan:
- WIDTH=32, SIZE=4. Send bytes 11 22 33 44, then start, with playback_enable held -> entry_count=1; one pattern_valid pulse with data 0x44332211, two cycles after start+enable; playing drops afterwards.
- WIDTH=12. Send 0xAB, 0xFC -> stored entry is 0xCAB; the upper nibble of the second byte is discarded.
- SIZE=4. Send 5 entries (20 bytes) -> entry_count=4, overflow=1; playback outputs only the first 4 entries, in order.
- Load 3 entries, start, toggle playback_enable 1,0,1,1 -> pattern_valid follows enable with 1-cycle lag; entries 0, 1, 2 appear once each, with no repeats.
- Inject a byte with stop bit = 0 between good bytes -> frame_error=1; that byte is not stored and assembly continues with the next good byte. Then clear -> all flags and counts return to 0.
- Pulse clear mid-playback on the cycle after an enabled read -> pattern_valid stays 0 on the next cycle; state is STATE_LOAD and entry_count=0.
